// File: rtl/dilithium_pkg.sv
// Shared constants and state type for the Dilithium polynomial samplers.
package dilithium_pkg;

   localparam int unsigned N                 = 256;
   localparam int unsigned COEFF_WIDTH       = 24;
   localparam int unsigned Q                 = 8380417;
   localparam int unsigned REJ_NTT_POLY_SEED = 272;
   localparam int unsigned DATA_IN_BITS      = 64;

   // Modulus at candidate width, so the rejection compare has matching widths
   localparam logic [22:0] Q_CAND = Q[22:0];

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEED = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } rej_state_t;

endpackage

// File: rtl/rej_ntt_poly_sampler_byte_fifo10.sv
// byte_fifo10: 10-byte shift buffer for the rejection sampler.
// Oldest byte sits in bits [7:0]. A push appends 8 bytes directly above the
// current fill; a pop drops the 3 oldest bytes. Push and pop never coincide
// because the caller only pushes while fewer than 3 bytes are held.
module byte_fifo10
   import dilithium_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_clear,
   input  logic                    i_push,
   input  logic [DATA_IN_BITS-1:0] i_push_data,
   input  logic                    i_pop,
   output logic [22:0]             o_head,
   output logic [3:0]              o_fill
);

   logic [79:0] r_buf;
   logic [3:0]  r_fill;
   logic [6:0]  w_shift;

   assign w_shift = {r_fill[3:0], 3'b000};

   // Buffer storage: clear, append a squeeze word above the fill, or drop three bytes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_buf  <= '0;
         r_fill <= '0;
      end else if (i_clear) begin
         r_buf  <= '0;
         r_fill <= '0;
      end else if (i_push) begin
         r_buf  <= r_buf | ({16'd0, i_push_data} << w_shift);
         r_fill <= r_fill + 4'd8;
      end else if (i_pop) begin
         r_buf  <= {24'd0, r_buf[79:24]};
         r_fill <= r_fill - 4'd3;
      end
   end

   // Only the low 23 bits of the three oldest bytes matter to the sampler
   assign o_head = r_buf[22:0];
   assign o_fill = r_fill;

endmodule

// File: rtl/rej_ntt_poly_sampler.sv
// rej_ntt_poly_sampler: latches a 34-byte seed, requests a SHAKE128 squeeze,
// rejection-samples 23-bit candidates against Q from the byte stream and
// writes 256 accepted coefficients to the polynomial RAM.
// Optional feature macro: REJ_NTT_POLY_STATS_EN adds the reject_cnt output.
module rej_ntt_poly_sampler
   import dilithium_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [REJ_NTT_POLY_SEED-1:0] rho,
   output logic                         done,
   output logic                         busy,
   output logic                         shake_start,
   output logic [REJ_NTT_POLY_SEED-1:0] shake_seed,
   input  logic                         shake_in_valid,
   input  logic [DATA_IN_BITS-1:0]      shake_in_data,
   output logic                         shake_in_ready,
   output logic                         coeff_we,
   output logic [7:0]                   coeff_addr,
   output logic [COEFF_WIDTH-1:0]       coeff_data
`ifdef REJ_NTT_POLY_STATS_EN
   ,
   output logic [15:0]                  reject_cnt
`endif
);

   rej_state_t  r_state;
   rej_state_t  w_next_state;
   logic [8:0]  r_acc_cnt;
   logic [3:0]  w_fill;
   logic [22:0] w_cand;
   logic        w_accept;
   logic        w_push;
   logic        w_pop;
   logic        w_clear;

   byte_fifo10 u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_clear     (w_clear),
      .i_push      (w_push),
      .i_push_data (shake_in_data),
      .i_pop       (w_pop),
      .o_head      (w_cand),
      .o_fill      (w_fill)
   );

   assign w_accept = (w_cand < Q_CAND);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state and handshake outputs; start overrides everything and restarts at SEED
   always_comb begin
      w_next_state   = r_state;
      shake_start    = 1'b0;
      done           = 1'b0;
      busy           = (r_state != IDLE);
      shake_in_ready = 1'b0;
      w_push         = 1'b0;
      w_pop          = 1'b0;
      w_clear        = 1'b0;
      case (r_state)
         IDLE: ;
         SEED: begin
            shake_start  = 1'b1;
            w_next_state = RUN;
         end
         RUN: begin
            if (r_acc_cnt[8]) begin
               w_next_state = DONE;
            end else begin
               shake_in_ready = (w_fill < 4'd3);
               w_push         = shake_in_valid && (w_fill < 4'd3);
               w_pop          = (w_fill >= 4'd3);
            end
         end
         DONE: begin
            done         = 1'b1;
            w_clear      = 1'b1;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
      if (start) begin
         w_next_state = SEED;
         w_clear      = 1'b1;
         w_push       = 1'b0;
         w_pop        = 1'b0;
      end
   end

   // Seed latch, accepted count and registered coefficient write port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shake_seed <= '0;
         r_acc_cnt  <= '0;
         coeff_we   <= 1'b0;
         coeff_addr <= '0;
         coeff_data <= '0;
      end else begin
         coeff_we <= 1'b0;
         if (start) begin
            shake_seed <= rho;
            r_acc_cnt  <= '0;
         end else if (w_pop && w_accept) begin
            coeff_we   <= 1'b1;
            coeff_addr <= r_acc_cnt[7:0];
            coeff_data <= {{(COEFF_WIDTH-23){1'b0}}, w_cand};
            r_acc_cnt  <= r_acc_cnt + 9'd1;
         end
      end
   end

`ifdef REJ_NTT_POLY_STATS_EN
   logic [15:0] r_reject_cnt;

   // Saturating count of rejected candidates, cleared by each new seed
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_reject_cnt <= '0;
      end else if (start) begin
         r_reject_cnt <= '0;
      end else if (w_pop && !w_accept && (r_reject_cnt != 16'hFFFF)) begin
         r_reject_cnt <= r_reject_cnt + 16'd1;
      end
   end

   assign reject_cnt = r_reject_cnt;
`endif

endmodule
